pe_noc_injector: RTL and testbench

PE-side transmit network interface for the bufferless XY mesh. It accepts result words from the local neuron through a valid/ready handshake and buffers them in a small FIFO. Each word is packetized and replicated to a parameterized set of destination nodes (the next layer's neurons), one packet per destination. Packets are driven into the switch's PE input port under that port's valid/ready rules.

---
 rtl/pe_noc_injector_if.sv | 23 ++
 rtl/pe_noc_injector.sv | 169 ++++++++++++++++
 tb/tb_pe_noc_injector.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_noc_injector_if.sv
// Handshake bundle between the neuron, the injector and the switch PE port.
// The slave modport is the injector's view; master is the neuron/switch side.
interface pe_noc_injector_if #(
  parameter int data_width  = 8,
  parameter int total_width = 16
) ();
  logic                   i_valid;
  logic [data_width-1:0]  i_data;
  logic                   o_ready;
  logic                   o_valid_sw;
  logic [total_width-1:0] o_data_sw;
  logic                   i_ready_sw;

  modport slave (
    input  i_valid, i_data, i_ready_sw,
    output o_ready, o_valid_sw, o_data_sw
  );

  modport master (
    output i_valid, i_data, i_ready_sw,
    input  o_ready, o_valid_sw, o_data_sw
  );
endinterface

// File: rtl/pe_noc_injector.sv
// PE transmit interface: FIFO-buffers neuron words and emits one packet per
// destination in row-major order. Macro PE_INJ_SKIP_SELF_EN suppresses self packets.
module pe_noc_injector #(
  parameter int x_coord     = 'd0,
  parameter int y_coord     = 'd0,
  parameter int X           = 4,
  parameter int Y           = 4,
  parameter int data_width  = 8,
  parameter int x_size      = 2,
  parameter int y_size      = 2,
  parameter int total_width = 2*x_size + 2*y_size + data_width,
  parameter int DEPTH       = 4,
  parameter int DEST_X0     = 'd0,
  parameter int DEST_Y0     = 'd1,
  parameter int NUM_DEST    = 2
) (
  input logic              clk,
  input logic              rstn,
  pe_noc_injector_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DC_W  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  localparam logic [x_size-1:0] SRC_X    = x_size'(x_coord);
  localparam logic [y_size-1:0] SRC_Y    = y_size'(y_coord);
  localparam logic [x_size-1:0] FIRST_X  = x_size'(DEST_X0);
  localparam logic [y_size-1:0] FIRST_Y  = y_size'(DEST_Y0);
  localparam logic [DC_W-1:0]   LAST_CNT = DC_W'(NUM_DEST - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [data_width-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ready_q, ready_d;
  state_t                 state_q, state_d;
  logic [DC_W-1:0]        dest_cnt_q, dest_cnt_d;
  logic [x_size-1:0]      dst_x_q, dst_x_d, nxt_x;
  logic [y_size-1:0]      dst_y_q, dst_y_d, nxt_y;
  logic                   valid_q, valid_d;
  logic [total_width-1:0] data_q, data_d;
  logic                   push, pop, advance, first_vld, next_vld;
  logic [data_width-1:0]  head, next_head;

  function automatic logic [total_width-1:0] pack(input logic [data_width-1:0] p,
                                                  input logic [x_size-1:0] dx,
                                                  input logic [y_size-1:0] dy);
    return {p, SRC_X, SRC_Y, dx, dy};
  endfunction

  // Row-major step; the Y wrap only guards against an out-of-range configuration.
  function automatic logic [x_size+y_size-1:0] next_dest(input logic [x_size-1:0] x,
                                                         input logic [y_size-1:0] y);
    logic [x_size-1:0] nx;
    logic [y_size-1:0] ny;
    nx = x + x_size'(1);
    ny = y;
    if (int'(x) == X - 1) begin
      nx = '0;
      ny = (int'(y) == Y - 1) ? '0 : y + y_size'(1);
    end
    return {nx, ny};
  endfunction

  assign {nxt_x, nxt_y} = next_dest(dst_x_q, dst_y_q);
  assign head           = mem_q[rd_ptr_q];
  assign next_head      = mem_q[rd_ptr_q + PTR_W'(1)];

`ifdef PE_INJ_SKIP_SELF_EN
  // A suppressed self slot carries valid=0 and moves on without waiting for the switch.
  assign first_vld = !((DEST_X0 == x_coord) && (DEST_Y0 == y_coord));
  assign next_vld  = !((int'(nxt_x) == x_coord) && (int'(nxt_y) == y_coord));
  assign advance   = valid_q ? bus.i_ready_sw : 1'b1;
`else
  assign first_vld = 1'b1;
  assign next_vld  = 1'b1;
  assign advance   = valid_q & bus.i_ready_sw;
`endif

  assign push     = bus.i_valid & ready_q;
  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign ready_d  = (count_d != CNT_W'(DEPTH));

  always_comb begin
    state_d    = state_q;
    dest_cnt_d = dest_cnt_q;
    dst_x_d    = dst_x_q;
    dst_y_d    = dst_y_q;
    valid_d    = valid_q;
    data_d     = data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d    = SEND;
          dest_cnt_d = '0;
          dst_x_d    = FIRST_X;
          dst_y_d    = FIRST_Y;
          valid_d    = first_vld;
          data_d     = pack(head, FIRST_X, FIRST_Y);
        end
      end
      SEND: begin
        if (advance) begin
          if (dest_cnt_q == LAST_CNT) begin
            pop = 1'b1;
            // Chain straight into the next queued word so back-to-back words have no bubble.
            if (count_q > CNT_W'(1)) begin
              dest_cnt_d = '0;
              dst_x_d    = FIRST_X;
              dst_y_d    = FIRST_Y;
              valid_d    = first_vld;
              data_d     = pack(next_head, FIRST_X, FIRST_Y);
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            dest_cnt_d = dest_cnt_q + DC_W'(1);
            dst_x_d    = nxt_x;
            dst_y_d    = nxt_y;
            valid_d    = next_vld;
            data_d     = pack(head, nxt_x, nxt_y);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      state_q    <= IDLE;
      dest_cnt_q <= '0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      dest_cnt_q <= dest_cnt_d;
      dst_x_q    <= dst_x_d;
      dst_y_q    <= dst_y_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid_sw = valid_q;
  assign bus.o_data_sw  = data_q;

endmodule

// File: tb/tb_pe_noc_injector.sv
// Bench for pe_noc_injector: two instances (plain fan-out; wrapping fan-out that
// includes its own node) share data and switch ready, with independent word valids.
module tb_pe_noc_injector;
  localparam int DW    = 8;
  localparam int TW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed { logic last; logic [TW-1:0] pkt; } beat_t;
  typedef struct { logic rdy; logic va; logic [TW-1:0] da; logic vb; logic [TW-1:0] db; } row_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rdy_sw;
  logic [DW-1:0] data;
  logic          iv   [2];
  logic          ov   [2];
  logic [TW-1:0] od   [2];
  logic          ordy [2];

  int            n_vec = 0;
  int            n_bad = 0;
  beat_t         expq [2][$];
  int            occ      [2];
  logic          exp_rdy  [2];
  logic          hold_pend[2];
  logic [TW-1:0] hold_dat [2];
  logic          acc      [2];
  beat_t         cur;
  row_t          tbl [6];

  always #5 clk = ~clk;

  pe_noc_injector_if #(.data_width(DW), .total_width(TW)) ifa ();
  pe_noc_injector_if #(.data_width(DW), .total_width(TW)) ifb ();

  assign ifa.i_valid = iv[0];
  assign ifa.i_data = data;
  assign ifa.i_ready_sw = rdy_sw;
  assign ifb.i_valid = iv[1];
  assign ifb.i_data = data;
  assign ifb.i_ready_sw = rdy_sw;
  assign ov[0] = ifa.o_valid_sw;
  assign od[0] = ifa.o_data_sw;
  assign ordy[0] = ifa.o_ready;
  assign ov[1] = ifb.o_valid_sw;
  assign od[1] = ifb.o_data_sw;
  assign ordy[1] = ifb.o_ready;

  pe_noc_injector #(.x_coord(3), .y_coord(0), .X(4), .Y(4), .data_width(DW), .x_size(2),
                    .y_size(2), .DEPTH(DEPTH), .DEST_X0(0), .DEST_Y0(1), .NUM_DEST(3))
    dut_a (.clk(clk), .rstn(rstn), .bus(ifa));

  pe_noc_injector #(.x_coord(1), .y_coord(1), .X(4), .Y(4), .data_width(DW), .x_size(2),
                    .y_size(2), .DEPTH(DEPTH), .DEST_X0(3), .DEST_Y0(0), .NUM_DEST(4))
    dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

  function automatic logic [TW-1:0] mk(input logic [7:0] w, input int sx, input int sy,
                                       input int dx, input int dy);
    return {w, 2'(sx), 2'(sy), 2'(dx), 2'(dy)};
  endfunction

  task automatic chk(input string name, input int inst, input logic [TW-1:0] got,
                     input logic [TW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // Reference: a word fans out to destinations at linear indices base..base+N-1 on the X=4 grid.
  task automatic add_word(input int i, input logic [7:0] w);
    int    sx, sy, x0, y0, nd, lin, dx, dy;
    beat_t tmp[$];
    sx = (i == 0) ? 3 : 1;
    sy = (i == 0) ? 0 : 1;
    x0 = (i == 0) ? 0 : 3;
    y0 = (i == 0) ? 1 : 0;
    nd = (i == 0) ? 3 : 4;
    for (int n = 0; n < nd; n++) begin
      lin = y0 * 4 + x0 + n;
      dx  = lin % 4;
      dy  = lin / 4;
`ifdef PE_INJ_SKIP_SELF_EN
      if (dx == sx && dy == sy) continue;
`endif
      tmp.push_back({1'b0, mk(w, sx, sy, dx, dy)});
    end
    tmp[tmp.size()-1].last = 1'b1;
    foreach (tmp[k]) expq[i].push_back(tmp[k]);
  endtask

  task automatic flush_model();
    for (int i = 0; i < 2; i++) begin
      expq[i].delete();
      occ[i]       = 0;
      exp_rdy[i]   = 1'b1;
      hold_pend[i] = 1'b0;
      hold_dat[i]  = '0;
      acc[i]       = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        if (ov[i] && rdy_sw) begin
          if (expq[i].size() == 0) begin
            chk("spurious_beat", i, od[i], 16'hxxxx);
          end else begin
            cur = expq[i].pop_front();
            chk("beat", i, od[i], cur.pkt);
            if (cur.last) occ[i]--;
          end
        end
        acc[i] = iv[i] && exp_rdy[i];
        if (acc[i]) begin
          add_word(i, data);
          occ[i]++;
        end
        exp_rdy[i]   = (occ[i] != DEPTH);
        hold_pend[i] = ov[i] && !rdy_sw;
        hold_dat[i]  = od[i];
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        chk("o_ready", i, 16'(ordy[i]), 16'(exp_rdy[i]));
        if (hold_pend[i]) begin
          chk("hold_valid", i, 16'(ov[i]), 16'(1));
          chk("hold_data", i, od[i], hold_dat[i]);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n      = 0;
    rdy_sw = 1'b1;
    iv[0]  = 1'b0;
    iv[1]  = 1'b0;
    while ((expq[0].size() != 0 || expq[1].size() != 0 || ov[0] || ov[1]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 0, 16'(expq[0].size()), 16'(0));
    chk(name, 1, 16'(expq[1].size()), 16'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn   = 1'b0;
    rdy_sw = 1'b0;
    data   = '0;
    iv[0]  = 1'b0;
    iv[1]  = 1'b0;
    flush_model();

    // Single word A5: first beat sampled by the switch at the second edge after the push edge.
    tbl[0] = '{1'b1, 1'b0, '0, 1'b0, '0};
    tbl[1] = '{1'b1, 1'b1, mk(8'hA5, 3, 0, 0, 1), 1'b1, mk(8'hA5, 1, 1, 3, 0)};
    tbl[2] = '{1'b1, 1'b1, mk(8'hA5, 3, 0, 1, 1), 1'b1, mk(8'hA5, 1, 1, 0, 1)};
`ifdef PE_INJ_SKIP_SELF_EN
    tbl[3] = '{1'b1, 1'b1, mk(8'hA5, 3, 0, 2, 1), 1'b0, '0};
`else
    tbl[3] = '{1'b1, 1'b1, mk(8'hA5, 3, 0, 2, 1), 1'b1, mk(8'hA5, 1, 1, 1, 1)};
`endif
    tbl[4] = '{1'b1, 1'b0, '0, 1'b1, mk(8'hA5, 1, 1, 2, 1)};
    tbl[5] = '{1'b1, 1'b0, '0, 1'b0, '0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, 16'(ov[i]), 16'(0));
      chk("rst_data", i, od[i], 16'(0));
      chk("rst_ready", i, 16'(ordy[i]), 16'(1));
    end
    rstn = 1'b1;

    @(negedge clk);
    data  = 8'hA5;
    iv[0] = 1'b1;
    iv[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rdy_sw = tbl[c].rdy;
      @(negedge clk);
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      chk("tbl_va", c, 16'(ov[0]), 16'(tbl[c].va));
      if (tbl[c].va) chk("tbl_da", c, od[0], tbl[c].da);
      chk("tbl_vb", c, 16'(ov[1]), 16'(tbl[c].vb));
      if (tbl[c].vb) chk("tbl_db", c, od[1], tbl[c].db);
    end

    // Backpressure on beat 2 of instance A for five cycles.
    data  = 8'h3C;
    iv[0] = 1'b1;
    iv[1] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rdy_sw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 0, 16'(ov[0]), 16'(1));
      chk("bp_data", 0, od[0], mk(8'h3C, 3, 0, 1, 1));
    end
    drain("bp_drain");

    // Fill: four words under backpressure, the fifth waits on o_ready.
    rdy_sw = 1'b0;
    for (int w = 0; w < 4; w++) begin
      data  = 8'(8'h10 + w);
      iv[0] = 1'b1;
      iv[1] = 1'b1;
      @(negedge clk);
    end
    data = 8'h55;
    for (int i = 0; i < 2; i++) chk("full_ready", i, 16'(ordy[i]), 16'(0));
    repeat (3) @(negedge clk);
    rdy_sw = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (acc[i]) iv[i] = 1'b0;
      chk("no_bubble", j, 16'(ov[0]), 16'(1));
    end
    for (int n = 0; n < 20 && (iv[0] || iv[1]); n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (acc[i]) iv[i] = 1'b0;
    end
    chk("fifth_taken", 0, 16'({iv[0], iv[1]}), 16'(0));
    drain("full_drain");

    // Reset with words queued while a packet is stalled.
    rdy_sw = 1'b0;
    for (int w = 0; w < 3; w++) begin
      data  = 8'(8'h70 + w);
      iv[0] = 1'b1;
      iv[1] = 1'b1;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    flush_model();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_valid", i, 16'(ov[i]), 16'(0));
      chk("mid_rst_ready", i, 16'(ordy[i]), 16'(1));
      chk("mid_rst_data", i, od[i], 16'(0));
    end
    @(negedge clk);
    rstn   = 1'b1;
    rdy_sw = 1'b1;
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("post_rst_idle", i, 16'(ov[i]), 16'(0));
    end

    // Random traffic against the reference queues.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rdy_sw = ($urandom_range(3) != 0);
      data   = 8'($urandom);
      iv[0]  = 1'($urandom);
      iv[1]  = 1'($urandom);
    end
    @(negedge clk);
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
